// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding and the target pattern shared by the serializer, detector and bench.
package seq_det_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAR   = 2'd2;
  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_PAR   = S_PAR
  } state_t;
  localparam logic [6:0] SEQ_PATTERN = 7'b1011010;
endpackage

// File: rtl/seq_serializer_if.sv
// seq_serializer_if: valid/ready word handshake between an upstream source and the serializer.
interface seq_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  modport master(output data_in, output data_valid, input data_ready);
  modport slave(input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/seq_serializer.sv
// seq_serializer: valid/ready parallel-to-serial shifter feeding the sequence detector.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after every word.
module seq_serializer
  import seq_det_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_serializer_if.slave in_if,
  output logic            seq_out,
  output logic            seq_valid,
  output logic            busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  seq_out_q, seq_out_d;
  logic                  seq_valid_q, seq_valid_d;
  logic                  load, last;
  assign last = cnt_q == CW'(DATA_WIDTH - 1);
  assign load = in_if.data_valid && in_if.data_ready;
`ifdef SEQ_SER_PARITY_EN
  logic par_q, par_d;
  assign par_d = load ? ^in_if.data_in : par_q;
  assign in_if.data_ready = state_q == ST_IDLE || state_q == ST_PAR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= 1'b0;
    else par_q <= par_d;
`else
  assign in_if.data_ready = state_q == ST_IDLE || (state_q == ST_SHIFT && last);
`endif
  // The shift register holds only the bits not yet on seq_out, so a reload on the
  // last-bit cycle continues the stream without a gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    seq_out_d   = IDLE_BIT;
    seq_valid_d = 1'b0;
    if (load) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      sh_d        = MSB_FIRST ? in_if.data_in << 1 : in_if.data_in >> 1;
      seq_out_d   = MSB_FIRST ? in_if.data_in[DATA_WIDTH-1] : in_if.data_in[0];
      seq_valid_d = 1'b1;
    end else if (state_q == ST_SHIFT && !last) begin
      cnt_d       = cnt_q + CW'(1);
      sh_d        = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
      seq_out_d   = MSB_FIRST ? sh_q[DATA_WIDTH-1] : sh_q[0];
      seq_valid_d = 1'b1;
`ifdef SEQ_SER_PARITY_EN
    end else if (state_q == ST_SHIFT) begin
      state_d     = ST_PAR;
      seq_out_d   = par_q;
      seq_valid_d = 1'b1;
`endif
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      seq_out_q   <= IDLE_BIT;
      seq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
    end
  assign seq_out   = seq_out_q;
  assign seq_valid = seq_valid_q;
  assign busy      = state_q != ST_IDLE;
endmodule
